pipe_wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the MEM/WB pipeline register output (WB stage) and a multi-cycle execution unit (mul/div) that completes out of band.
- The WB stage always has priority. Multi-cycle results are held in a small FIFO and drained on cycles where WB does not write.
- A starvation counter raises a stall request so the hazard unit can insert a bubble when WB writes back-to-back for too long.
- Sits between the MEM/WB register and the register file write port. It also provides a pending-write lookup for the hazard/interlock unit.

---
 rtl/pipe_wb_port_arbiter_if.sv | 49 ++++
 rtl/pipe_wb_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_pipe_wb_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_wb_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// pipe_wb_port_arbiter_if
//   Bundles every signal around the shared register-file write port:
//     WB stage      : wwreg, wrn, wd
//     mul/div unit  : mc_valid, mc_ready, mc_rn, mc_d
//     hazard unit   : qrn, pend_hit, stall_req
//     register file : rf_we, rf_wn, rf_d
//     status        : fifo_cnt (registered FIFO occupancy, 0..DEPTH)
//   slave  : the arbiter's view (drives handshake responses and the port)
//   master : the surrounding pipeline / testbench view
// ----------------------------------------------------------------------------
interface pipe_wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wwreg;
    logic [4:0]    wrn;
    logic [31:0]   wd;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_rn;
    logic [31:0]   mc_d;
    logic [4:0]    qrn;
    logic          pend_hit;
    logic          rf_we;
    logic [4:0]    rf_wn;
    logic [31:0]   rf_d;
    logic          stall_req;
    logic [CW-1:0] fifo_cnt;

    modport slave (
        input  wwreg, wrn, wd,
        input  mc_valid, mc_rn, mc_d,
        input  qrn,
        output mc_ready, pend_hit,
        output rf_we, rf_wn, rf_d,
        output stall_req, fifo_cnt
    );

    modport master (
        output wwreg, wrn, wd,
        output mc_valid, mc_rn, mc_d,
        output qrn,
        input  mc_ready, pend_hit,
        input  rf_we, rf_wn, rf_d,
        input  stall_req, fifo_cnt
    );
endinterface

// File: rtl/pipe_wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// pipe_wb_port_arbiter
//   Shares the single register-file write port between the WB stage and an
//   out-of-band multi-cycle unit. WB always wins; multi-cycle results wait in
//   a small FIFO and drain on cycles where WB does not write. A starvation
//   counter raises stall_req so the hazard unit can open a bubble.
//
//   Ports:
//     clk  : system clock, all state on posedge
//     clr  : synchronous active-high reset
//     bus  : pipe_wb_port_arbiter_if.slave (WB inputs, mc handshake,
//            pending-write lookup, register-file port, stall_req, fifo_cnt)
//
//   Parameters:
//     DEPTH      : FIFO entries, power of two, >= 2
//     STARVE_LIM : consecutive lost port cycles before stall_req (1..15)
// ----------------------------------------------------------------------------
module pipe_wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    pipe_wb_port_arbiter_if.slave  bus
);
    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]     LIM      = 4'(STARVE_LIM);

    // FIFO storage and control
    logic [4:0]    rn_q  [DEPTH];
    logic [4:0]    rn_d  [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   dat_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // starvation tracking
    logic [3:0]    starve_q, starve_d;
    logic          stall_q, stall_d;

    logic          empty;
    logic          full;
    logic          pipe_wr;
    logic          mc_ready;
    logic          push;
    logic          pop;

    // ------------------------------------------------------------------
    // Handshake / arbitration decisions
    // ------------------------------------------------------------------
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == FULL_CNT);
        // A WB write to r0 is not a write; the port is free that cycle.
        pipe_wr  = bus.wwreg && (bus.wrn != 5'd0);
        // Readiness looks only at the registered count, so a same-cycle pop
        // never makes room for a push into a full FIFO.
        mc_ready = !full && !clr;
        // Results for r0 are accepted and silently dropped.
        push     = bus.mc_valid && mc_ready && (bus.mc_rn != 5'd0);
        pop      = !clr && !pipe_wr && !empty;
    end

    // ------------------------------------------------------------------
    // Write-port mux: WB first, else FIFO head. Address/data are forced to
    // zero whenever nothing is written so the port never shows stale values.
    // ------------------------------------------------------------------
    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wn = 5'd0;
        bus.rf_d  = 32'd0;
        if (!clr) begin
            if (pipe_wr) begin
                bus.rf_we = 1'b1;
                bus.rf_wn = bus.wrn;
                bus.rf_d  = bus.wd;
            end else if (!empty) begin
                bus.rf_we = 1'b1;
                bus.rf_wn = rn_q[rd_ptr_q];
                bus.rf_d  = dat_q[rd_ptr_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-write lookup: walk the live window starting at the read
    // pointer so only occupied slots can hit.
    // ------------------------------------------------------------------
    always_comb begin
        logic [PW-1:0] slot;
        bus.pend_hit = 1'b0;
        slot         = '0;
        if (!clr && (bus.qrn != 5'd0)) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot = rd_ptr_q + PW'(k);
                if ((CW'(k) < cnt_q) && (rn_q[slot] == bus.qrn)) begin
                    bus.pend_hit = 1'b1;
                end
            end
        end
    end

    assign bus.mc_ready  = mc_ready;
    assign bus.stall_req = stall_q;
    assign bus.fifo_cnt  = cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rn_d     = rn_q;
        dat_d    = dat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;

        if (push) begin
            rn_d[wr_ptr_q]  = bus.mc_rn;
            dat_d[wr_ptr_q] = bus.mc_d;
            // DEPTH is a power of two, so natural pointer overflow wraps.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Count cycles where a queued result lost the port to WB.
        if (pop || empty) begin
            starve_d = 4'd0;
        end else if (pipe_wr && (starve_q != LIM)) begin
            starve_d = starve_q + 4'd1;
        end

        // Registered request; a pop zeroes the counter so the request drops
        // the cycle after the FIFO finally gets the port.
        stall_d = (starve_d == LIM);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                rn_q[i]  <= 5'd0;
                dat_q[i] <= 32'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            rn_q     <= rn_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipe_wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pipe_wb_port_arbiter
//   Directed scenarios with literal expectations followed by randomized
//   traffic. A queue-based reference model predicts every output each cycle;
//   outputs are sampled on the falling edge, inputs change 1ns after rising.
// ----------------------------------------------------------------------------
module tb_pipe_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    pipe_wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    pipe_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [4:0]  mq_rn[$];
    logic [31:0] mq_d[$];
    int          m_starve = 0;
    logic        m_stall  = 1'b0;

    // per-cycle decisions carried from cyc() to adv()
    logic        m_clr, m_pw, m_pop, m_push;
    logic [4:0]  m_rn;
    logic [31:0] m_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then at the falling edge compare every
    // output against what the model says it must be.
    task automatic cyc(input logic c, input logic ww, input logic [4:0] wn,
                       input logic [31:0] d, input logic mv, input logic [4:0] mrn,
                       input logic [31:0] md, input logic [4:0] q);
        logic        full, e_rdy, e_we, e_pend;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        clr          = c;
        bus.wwreg    = ww;
        bus.wrn      = wn;
        bus.wd       = d;
        bus.mc_valid = mv;
        bus.mc_rn    = mrn;
        bus.mc_d     = md;
        bus.qrn      = q;

        full   = (mq_rn.size() == DEPTH);
        e_rdy  = 1'b0; e_we = 1'b0; e_pend = 1'b0; e_wn = 5'd0; e_d = 32'd0;
        m_clr  = c;
        m_pw   = ww && (wn != 5'd0);
        m_pop  = 1'b0;
        m_push = 1'b0;
        m_rn   = mrn;
        m_d    = md;
        if (!c) begin
            e_rdy = !full;
            if (m_pw) begin
                e_we = 1'b1; e_wn = wn; e_d = d;
            end else if (mq_rn.size() > 0) begin
                e_we = 1'b1; e_wn = mq_rn[0]; e_d = mq_d[0];
                m_pop = 1'b1;
            end
            foreach (mq_rn[i]) if (q != 5'd0 && mq_rn[i] == q) e_pend = 1'b1;
            m_push = mv && !full && (mrn != 5'd0);
        end

        @(negedge clk);
        chk("rf_we",     32'(bus.rf_we),     32'(e_we));
        chk("rf_wn",     32'(bus.rf_wn),     32'(e_wn));
        chk("rf_d",      bus.rf_d,           e_d);
        chk("mc_ready",  32'(bus.mc_ready),  32'(e_rdy));
        chk("pend_hit",  32'(bus.pend_hit),  32'(e_pend));
        chk("fifo_cnt",  32'(bus.fifo_cnt),  32'(mq_rn.size()));
        chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
    endtask

    // Advance the model across the rising edge and move to the next cycle.
    task automatic adv();
        logic was_empty;
        if (m_clr) begin
            mq_rn.delete(); mq_d.delete();
            m_starve = 0;
            m_stall  = 1'b0;
        end else begin
            was_empty = (mq_rn.size() == 0);
            if (m_pop) begin
                void'(mq_rn.pop_front()); void'(mq_d.pop_front());
            end
            if (m_push) begin
                mq_rn.push_back(m_rn); mq_d.push_back(m_d);
            end
            if (m_pop || was_empty) m_starve = 0;
            else if (m_pw && m_starve < LIM) m_starve++;
            m_stall = (m_starve == LIM);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wprob;
        logic        r_ww, r_mv, r_clr;
        logic [4:0]  r_wn, r_mrn, r_q;

        // reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        adv();
        cyc(1, 1, 5'd3, 32'h55, 1, 5'd2, 32'h66, 0);
        chk("clr_rf_we", 32'(bus.rf_we), 0);
        chk("clr_mc_ready", 32'(bus.mc_ready), 0);
        adv();

        // idle after reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_rf_we", 32'(bus.rf_we), 0);
        chk("idle_mc_ready", 32'(bus.mc_ready), 1);
        chk("idle_fifo_cnt", 32'(bus.fifo_cnt), 0);
        chk("idle_stall", 32'(bus.stall_req), 0);
        adv();

        // WB write, same-cycle port
        cyc(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);
        chk("wb_we", 32'(bus.rf_we), 1);
        chk("wb_wn", 32'(bus.rf_wn), 5);
        chk("wb_d", bus.rf_d, 32'h1234);
        adv();

        // single mc result, no bypass, drains next cycle
        cyc(0, 0, 0, 0, 1, 5'd7, 32'hCAFE, 5'd7);
        chk("mc_nobypass_we", 32'(bus.rf_we), 0);
        chk("mc_pend_before", 32'(bus.pend_hit), 0);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0, 5'd7);
        chk("mc_we", 32'(bus.rf_we), 1);
        chk("mc_wn", 32'(bus.rf_wn), 7);
        chk("mc_d", bus.rf_d, 32'hCAFE);
        chk("mc_pend_queued", 32'(bus.pend_hit), 1);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0, 5'd7);
        chk("mc_cnt_after", 32'(bus.fifo_cnt), 0);
        chk("mc_pend_after", 32'(bus.pend_hit), 0);
        adv();

        // fill under continuous WB pressure, starvation, then drain
        cyc(0, 1, 5'd9, 32'h9, 1, 5'd3, 32'h333, 0);
        adv();
        cyc(0, 1, 5'd9, 32'h9, 1, 5'd4, 32'h444, 0);
        chk("fill_cnt1", 32'(bus.fifo_cnt), 1);
        adv();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 5'd9, 32'h9, 0, 0, 0, 5'd4);
            if (i == 0) begin
                chk("full_ready", 32'(bus.mc_ready), 0);
                chk("full_cnt", 32'(bus.fifo_cnt), 2);
                chk("full_pend", 32'(bus.pend_hit), 1);
            end
            if (i == 2) chk("starve_pre", 32'(bus.stall_req), 0);
            if (i == 3) chk("starve_stall", 32'(bus.stall_req), 1);
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain1_wn", 32'(bus.rf_wn), 3);
        chk("drain1_d", bus.rf_d, 32'h333);
        chk("drain1_stall", 32'(bus.stall_req), 1);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain2_wn", 32'(bus.rf_wn), 4);
        chk("drain2_stall", 32'(bus.stall_req), 0);
        adv();

        // mc_rn=0 and WB to r0: nothing written, nothing queued
        cyc(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hBEEF, 0);
        chk("r0_we", 32'(bus.rf_we), 0);
        chk("r0_ready", 32'(bus.mc_ready), 1);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_cnt", 32'(bus.fifo_cnt), 0);
        adv();

        // full FIFO: pop with simultaneous mc_valid is refused, then clr
        cyc(0, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA0, 0);
        adv();
        cyc(0, 1, 5'd9, 32'h9, 1, 5'd11, 32'hB0, 0);
        adv();
        cyc(0, 0, 0, 0, 1, 5'd12, 32'hC0, 0);
        chk("fullpop_ready", 32'(bus.mc_ready), 0);
        chk("fullpop_wn", 32'(bus.rf_wn), 10);
        adv();
        cyc(0, 1, 5'd9, 32'h9, 0, 0, 0, 5'd12);
        chk("fullpop_cnt", 32'(bus.fifo_cnt), 1);
        chk("fullpop_pend12", 32'(bus.pend_hit), 0);
        adv();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd11);
        chk("midclr_we", 32'(bus.rf_we), 0);
        adv();
        cyc(0, 0, 0, 0, 0, 0, 0, 5'd11);
        chk("postclr_cnt", 32'(bus.fifo_cnt), 0);
        chk("postclr_we", 32'(bus.rf_we), 0);
        chk("postclr_pend", 32'(bus.pend_hit), 0);
        adv();

        // randomized traffic with varying WB pressure
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       wprob = 95;
                1:       wprob = 60;
                2:       wprob = 30;
                default: wprob = 85;
            endcase
            for (int n = 0; n < 500; n++) begin
                r_clr = ($urandom_range(0, 199) == 0);
                r_ww  = ($urandom_range(0, 99) < wprob);
                r_wn  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_mv  = ($urandom_range(0, 1) == 1);
                r_mrn = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
                r_q   = 5'($urandom_range(0, 15));
                cyc(r_clr, r_ww, r_wn, $urandom, r_mv, r_mrn, $urandom, r_q);
                adv();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
